// File: rtl/outport_arb.sv
// rtl/outport_arb.sv - round-robin output-port arbiter with packet lock and stall watchdog
//
// Purpose: one arbiter per router output port. It picks one of five input channels
// requesting this port (round-robin, after the previous owner), then locks the port
// to that channel until its tail flit is accepted, the channel withdraws its request,
// or the stall watchdog fires.
//
// Ports:
//   clk                 clock, rising edge
//   rst_                asynchronous active-low reset
//   req_0..req_4        per-channel request
//   port_0..port_4      per-channel requested output port
//   ivalid_0..ivalid_4  per-channel flit valid on the crossbar
//   itype_0..itype_4    per-channel flit type
//   dn_rdy              downstream buffer can accept a flit
//   grt_0..grt_4        per-channel grant (combinational)
//   busy                port locked to an owner
//   owner               current or last owner index
//   stall_err           sticky watchdog flag

`ifndef PORTW
`define PORTW 2
`endif
`ifndef TYPEW
`define TYPEW 2
`endif
`ifndef TYPE_NONE
`define TYPE_NONE     3'd0
`define TYPE_HEAD     3'd1
`define TYPE_BODY     3'd2
`define TYPE_TAIL     3'd3
`define TYPE_HEADTAIL 3'd4
`endif

module outport_arb #(
  parameter int         ROUTERID = 0,
  parameter int         PORTID   = 0,
  parameter logic [7:0] STALLMAX = 8'd255
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            req_0,
  input  logic            req_1,
  input  logic            req_2,
  input  logic            req_3,
  input  logic            req_4,
  input  logic [`PORTW:0] port_0,
  input  logic [`PORTW:0] port_1,
  input  logic [`PORTW:0] port_2,
  input  logic [`PORTW:0] port_3,
  input  logic [`PORTW:0] port_4,
  input  logic            ivalid_0,
  input  logic            ivalid_1,
  input  logic            ivalid_2,
  input  logic            ivalid_3,
  input  logic            ivalid_4,
  input  logic [`TYPEW:0] itype_0,
  input  logic [`TYPEW:0] itype_1,
  input  logic [`TYPEW:0] itype_2,
  input  logic [`TYPEW:0] itype_3,
  input  logic [`TYPEW:0] itype_4,
  input  logic            dn_rdy,
  output logic            grt_0,
  output logic            grt_1,
  output logic            grt_2,
  output logic            grt_3,
  output logic            grt_4,
  output logic            busy,
  output logic [2:0]      owner,
  output logic            stall_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_e;

  // Router index only identifies the instance in debug; a negative value is meaningless.
  if (ROUTERID < 0) begin : g_bad_routerid
  end

  localparam logic [`PORTW:0] PORT_SEL = PORTID[`PORTW:0];

  state_e          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      last_q, last_d;
  logic [7:0]      stall_q, stall_d;
  logic            err_q, err_d;

  logic [4:0]      req_v, ivalid_v, grt_v, elig;
  logic [`PORTW:0] port_v [5];
  logic [`TYPEW:0] type_v [5];
  logic [2:0]      win;
  logic            accept, tail_rel, own_req, stall_hit;

  assign req_v    = {req_4, req_3, req_2, req_1, req_0};
  assign ivalid_v = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
  assign port_v   = '{port_0, port_1, port_2, port_3, port_4};
  assign type_v   = '{itype_0, itype_1, itype_2, itype_3, itype_4};

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      elig[i]  = req_v[i] && (port_v[i] == PORT_SEL);
      grt_v[i] = (state_q == ST_LOCK) && (owner_q == 3'(i)) && dn_rdy;
    end
  end

  // Round-robin search starting just after the last owner, wrapping 4 -> 0.
  always_comb begin
    logic [3:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= 5; k++) begin
      idx = {1'b0, last_q} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && elig[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
  end

  assign accept   = grt_v[owner_q] && ivalid_v[owner_q];
  assign tail_rel = accept && ((type_v[owner_q] == `TYPE_TAIL) ||
                               (type_v[owner_q] == `TYPE_HEADTAIL));
  assign own_req  = req_v[owner_q];
  // Fires on the cycle whose increment would bring the counter to the limit.
  assign stall_hit = (state_q == ST_LOCK) && !accept &&
                     (({1'b0, stall_q} + 9'd1) >= {1'b0, STALLMAX});

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    stall_d = stall_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (|elig) begin
          state_d = ST_LOCK;
          owner_d = win;
        end
      end
      ST_LOCK: begin
        if (accept) stall_d = '0;
        else if (stall_q != STALLMAX) stall_d = stall_q + 8'd1;
        if (stall_hit) err_d = 1'b1;
        if (tail_rel || !own_req || stall_hit) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          stall_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      owner_q <= 3'd0;
      last_q  <= 3'd4;
      stall_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grt_v;
  assign busy      = (state_q == ST_LOCK);
  assign owner     = owner_q;
  assign stall_err = err_q;

endmodule

// File: tb/tb_outport_arb.sv
// tb/tb_outport_arb.sv - directed table-driven bench for outport_arb

`ifndef PORTW
`define PORTW 2
`endif
`ifndef TYPEW
`define TYPEW 2
`endif
`ifndef TYPE_NONE
`define TYPE_NONE     3'd0
`define TYPE_HEAD     3'd1
`define TYPE_BODY     3'd2
`define TYPE_TAIL     3'd3
`define TYPE_HEADTAIL 3'd4
`endif

module tb_outport_arb;

  localparam int PID = 2;

  logic            clk = 1'b0;
  logic            rst_;
  logic [4:0]      req, ivalid;
  logic [`PORTW:0] port [5];
  logic [`TYPEW:0] itype [5];
  logic            dn_rdy;
  logic            grt_0, grt_1, grt_2, grt_3, grt_4;
  logic            busy, stall_err;
  logic [2:0]      owner;
  logic [4:0]      grt;

  assign grt = {grt_4, grt_3, grt_2, grt_1, grt_0};

  always #5 clk = ~clk;

  outport_arb #(.ROUTERID(0), .PORTID(PID), .STALLMAX(8'd4)) dut (
    .clk(clk), .rst_(rst_),
    .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]), .req_4(req[4]),
    .port_0(port[0]), .port_1(port[1]), .port_2(port[2]), .port_3(port[3]), .port_4(port[4]),
    .ivalid_0(ivalid[0]), .ivalid_1(ivalid[1]), .ivalid_2(ivalid[2]),
    .ivalid_3(ivalid[3]), .ivalid_4(ivalid[4]),
    .itype_0(itype[0]), .itype_1(itype[1]), .itype_2(itype[2]),
    .itype_3(itype[3]), .itype_4(itype[4]),
    .dn_rdy(dn_rdy),
    .grt_0(grt_0), .grt_1(grt_1), .grt_2(grt_2), .grt_3(grt_3), .grt_4(grt_4),
    .busy(busy), .owner(owner), .stall_err(stall_err)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] req;
    logic [4:0] pm;    // 1 = channel asks for this port, 0 = some other port
    logic [4:0] iv;
    logic [2:0] typ;
    logic       dn;
    logic [4:0] eg;
    logic       eb;
    logic [2:0] eo;
    logic       ee;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(string nm, logic r, logic [4:0] rq, logic [4:0] pm,
                              logic [4:0] iv, logic [2:0] ty, logic dn,
                              logic [4:0] eg, logic eb, logic [2:0] eo, logic ee);
    vec_t v;
    v.name = nm; v.rst = r; v.req = rq; v.pm = pm; v.iv = iv; v.typ = ty; v.dn = dn;
    v.eg = eg; v.eb = eb; v.eo = eo; v.ee = ee;
    vq.push_back(v);
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [4:0] rq, logic [4:0] pm, logic [4:0] iv,
                       logic [2:0] ty, logic dn);
    rst_   = r;
    req    = rq;
    ivalid = iv;
    dn_rdy = dn;
    for (int i = 0; i < 5; i++) begin
      port[i]  = pm[i] ? 3'(PID) : 3'd5;
      itype[i] = ty;
    end
  endtask

  initial begin
    drive(1'b0, 5'b0, 5'h1F, 5'b0, `TYPE_NONE, 1'b1);

    // Reset, then channels 1 and 3 with tail on ch1, then ch3.
    add("rst",       0, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);
    add("arb13",     1, 5'b01010, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);
    add("lock1",     1, 5'b01010, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00010, 1, 3'd1, 0);
    add("tail1",     1, 5'b01010, 5'h1F, 5'b00010, `TYPE_TAIL,     1, 5'b00010, 1, 3'd1, 0);
    add("bubble1",   1, 5'b01010, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd1, 0);
    add("lock3",     1, 5'b01010, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b01000, 1, 3'd3, 0);
    add("ht3",       1, 5'b01010, 5'h1F, 5'b01000, `TYPE_HEADTAIL, 1, 5'b01000, 1, 3'd3, 0);
    add("idle3",     1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd3, 0);

    // All five eligible, one HEADTAIL per grant: 0,1,2,3,4,0 with bubbles.
    add("rst2",      0, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);
    add("rr_arb",    1, 5'b11111, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);
    for (int g = 0; g < 5; g++) begin
      add($sformatf("rr_grant%0d", g), 1, 5'b11111, 5'h1F, 5'b11111, `TYPE_HEADTAIL, 1,
          5'(1 << g), 1, 3'(g), 0);
      add($sformatf("rr_bubble%0d", g), 1, 5'b11111, 5'h1F, 5'b11111, `TYPE_HEADTAIL, 1,
          5'b00000, 0, 3'(g), 0);
    end
    add("rr_wrap0",  1, 5'b11111, 5'h1F, 5'b11111, `TYPE_HEADTAIL, 1, 5'b00001, 1, 3'd0, 0);
    add("rr_done",   1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);

    // Owner ch2: HEAD, 3 cycles back-pressure, BODY, TAIL.
    add("bp_arb",    1, 5'b00100, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);
    add("bp_head",   1, 5'b00100, 5'h1F, 5'b00100, `TYPE_HEAD,     1, 5'b00100, 1, 3'd2, 0);
    for (int c = 0; c < 3; c++)
      add($sformatf("bp_stall%0d", c), 1, 5'b00100, 5'h1F, 5'b00100, `TYPE_BODY, 0,
          5'b00000, 1, 3'd2, 0);
    add("bp_body",   1, 5'b00100, 5'h1F, 5'b00100, `TYPE_BODY,     1, 5'b00100, 1, 3'd2, 0);
    add("bp_tail",   1, 5'b00100, 5'h1F, 5'b00100, `TYPE_TAIL,     1, 5'b00100, 1, 3'd2, 0);
    add("bp_idle",   1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd2, 0);

    // Owner ch4 aborts mid-packet; ch0 then has top priority.
    add("ab_arb",    1, 5'b10000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd2, 0);
    add("ab_head",   1, 5'b10000, 5'h1F, 5'b10000, `TYPE_HEAD,     1, 5'b10000, 1, 3'd4, 0);
    add("ab_drop",   1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b10000, 1, 3'd4, 0);
    add("ab_idle",   1, 5'b11111, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd4, 0);
    add("ab_next0",  1, 5'b11111, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00001, 1, 3'd0, 0);
    add("ab_drop0",  1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00001, 1, 3'd0, 0);
    add("ab_done",   1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);

    // Watchdog with STALLMAX = 4: ch1 holds request, sends nothing.
    add("wd_arb",    1, 5'b00010, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);
    for (int c = 0; c < 4; c++)
      add($sformatf("wd_lock%0d", c), 1, 5'b00010, 5'h1F, 5'b00000, `TYPE_NONE, 1,
          5'b00010, 1, 3'd1, 0);
    add("wd_fired",  1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd1, 1);
    add("wd_sticky", 1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd1, 1);

    // Requests for other ports never win this one.
    for (int c = 0; c < 3; c++)
      add($sformatf("other_port%0d", c), 1, 5'b11111, 5'h00, 5'b00000, `TYPE_NONE, 1,
          5'b00000, 0, 3'd1, 1);
    add("rst3",      0, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);

    // NONE-typed valid flits do not release the lock.
    add("none_arb",  1, 5'b01000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd0, 0);
    add("none_a",    1, 5'b01000, 5'h1F, 5'b01000, `TYPE_NONE,     1, 5'b01000, 1, 3'd3, 0);
    add("none_b",    1, 5'b01000, 5'h1F, 5'b01000, `TYPE_NONE,     1, 5'b01000, 1, 3'd3, 0);
    add("none_tail", 1, 5'b01000, 5'h1F, 5'b01000, `TYPE_TAIL,     1, 5'b01000, 1, 3'd3, 0);
    add("none_idle", 1, 5'b00000, 5'h1F, 5'b00000, `TYPE_NONE,     1, 5'b00000, 0, 3'd3, 0);

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      drive(vq[n].rst, vq[n].req, vq[n].pm, vq[n].iv, vq[n].typ, vq[n].dn);
      #2;
      chk({vq[n].name, ".grt"},       8'(grt),       8'(vq[n].eg));
      chk({vq[n].name, ".busy"},      8'(busy),      8'(vq[n].eb));
      chk({vq[n].name, ".owner"},     8'(owner),     8'(vq[n].eo));
      chk({vq[n].name, ".stall_err"}, 8'(stall_err), 8'(vq[n].ee));
    end

    // Asynchronous reset while locked drops the grant without a clock edge.
    @(negedge clk);
    drive(1'b1, 5'b00001, 5'h1F, 5'b00000, `TYPE_NONE, 1'b1);
    @(negedge clk);
    #2;
    chk("async_pre.grt", 8'(grt), 8'h01);
    #1 rst_ = 1'b0;
    #1;
    chk("async_rst.grt",  8'(grt),  8'h00);
    chk("async_rst.busy", 8'(busy), 8'h00);

    // First arbitration after reset starts from channel 0.
    @(negedge clk);
    drive(1'b1, 5'b01001, 5'h1F, 5'b00000, `TYPE_NONE, 1'b1);
    @(negedge clk);
    #2;
    chk("post_rst.grt",   8'(grt),   8'h01);
    chk("post_rst.owner", 8'(owner), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/outport_arb.md
OUTPORT_ARB -- requirements
Module: outport_arb

Interface
REQ-001 SHALL have parameter ROUTERID, default 0, router index (used for debug display only).
REQ-002 SHALL have parameter PORTID, default 0, index of the output port this arbiter owns; it is compared against each requester's port field.
REQ-003 SHALL have parameter STALLMAX, default 255, watchdog limit in cycles (8-bit).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_  input  1  reset, asynchronous, active-low.
REQ-006 req_0..req_4  input  1 each  request from input channel i.
REQ-007 port_0..port_4  input  `PORTW+1 each  requested output port of channel i.
REQ-008 ivalid_0..ivalid_4  input  1 each  flit from channel i is on the crossbar this cycle.
REQ-009 itype_0..itype_4  input  `TYPEW+1 each  type field of that flit.
REQ-010 dn_rdy  input  1  downstream buffer of this output can accept a flit.
REQ-011 grt_0..grt_4  output  1 each  grant to channel i.
REQ-012 busy  output  1  port locked to an owner.
REQ-013 owner  output  3  index of the current or last owner (0-4).
REQ-014 stall_err  output  1  watchdog fired; sticky until reset.

Function
REQ-015 Eligible set elig[i] SHALL be req_i && (port_i == PORTID).
REQ-016 FSM SHALL have states IDLE and LOCK; busy = (state == LOCK).
REQ-017 In IDLE with any elig bit set, the FSM SHALL select a winner by round-robin, searching from (last+1) mod 5 upward with wrap 4->0, where last is the previous owner.
REQ-018 In that IDLE case, the winner SHALL be registered into owner and the FSM SHALL enter LOCK on the next edge, giving one cycle of arbitration latency. dn_rdy does not gate arbitration.
REQ-019 In IDLE with no elig bit set, the state, owner and last SHALL all hold.
REQ-020 grt_i SHALL be combinational: (state == LOCK) && (owner == i) && dn_rdy.
REQ-021 At most one grt SHALL be high in any cycle. All grants SHALL be 0 in IDLE.
REQ-022 In LOCK, a release SHALL occur on the edge where grt_owner && ivalid_owner && itype_owner is `TYPE_TAIL or `TYPE_HEADTAIL.
REQ-023 In LOCK, a release SHALL also occur when req_owner is low (abort).
REQ-024 On release the FSM SHALL go to IDLE and last SHALL be set to owner; owner keeps its value.
REQ-025 Release and a new eligible request in the same cycle SHALL give IDLE for one cycle (bubble). The released owner SHALL get lowest priority in the next arbitration.
REQ-026 In LOCK, a HEAD or BODY flit (grt && ivalid && other type) SHALL NOT release.
REQ-027 `TYPE_NONE with ivalid SHALL be ignored.
REQ-028 The 8-bit stall counter SHALL clear on entry to LOCK and on every accepted flit (grt_owner && ivalid_owner).
REQ-029 The stall counter SHALL otherwise increment in LOCK and saturate at STALLMAX.
REQ-030 When the stall counter reaches STALLMAX, stall_err SHALL set, and the FSM SHALL force a release (last = owner, go to IDLE) on the same edge.
REQ-031 The stall counter SHALL hold at 0 in IDLE.
REQ-032 dn_rdy low in LOCK SHALL keep the lock and the stall counter SHALL keep counting; back-pressure therefore counts toward the watchdog.

Reset
REQ-033 While rst_ = 0, the block SHALL hold: state = IDLE, owner = 0, last = 4 (channel 0 gets first priority), stall counter = 0, stall_err = 0, all grt = 0, busy = 0.
REQ-034 Reset asserted in LOCK SHALL drop grants immediately (asynchronously). The first arbitration after release of reset SHALL start from channel 0.

Verification
REQ-035 Scenario: reset release; elig = {1,3} with dn_rdy = 1 -> cycle 1 grt_1 = 1, owner = 1; a TAIL on ch1 -> IDLE; next arbitration grants ch3.
REQ-036 Scenario: all five eligible, each sends a HEADTAIL per grant -> grant order 0,1,2,3,4,0 with one IDLE bubble between grants.
REQ-037 Scenario: owner ch2 sends HEAD, then dn_rdy = 0 for 3 cycles, then BODY and TAIL -> grt_2 low for exactly those 3 cycles, lock held, release only after TAIL.
REQ-038 Scenario: owner ch4 drops req mid-packet -> IDLE next edge, last = 4, ch0 has top priority.
REQ-039 Scenario: STALLMAX = 4, owner holds req with no flits -> stall_err = 1 and busy = 0 after 4 LOCK cycles; stall_err stays 1 until rst_ = 0.
REQ-040 Scenario: port_i != PORTID with req_i = 1 -> never granted; busy stays 0.
